// File: rtl/ft_rca_pkg.sv
// Shared types and helpers for the ripple-carry adder BIST controller.
//   state_e    : controller FSM states
//   PAT_FIRST  : first test code of every unit's sequence
//   PAT_LAST   : final test code of every unit's sequence
//   next_pat   : successor in the 8-state test code sequence
//   expand_op  : repeats a 3-bit code across an operand, truncated to width
package ft_rca_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_APPLY,
    ST_CHECK,
    ST_SELECT,
    ST_DONE
  } state_e;

  localparam logic [2:0] PAT_FIRST = 3'b001;
  localparam logic [2:0] PAT_LAST  = 3'b111;

  // 001 -> 010 -> 100 -> 110 -> 000 -> 011 -> 101 -> 111 -> 001
  function automatic logic [2:0] next_pat(input logic [2:0] p);
    logic [2:0] n;
    case (p)
      3'b001:  n = 3'b010;
      3'b010:  n = 3'b100;
      3'b100:  n = 3'b110;
      3'b110:  n = 3'b000;
      3'b000:  n = 3'b011;
      3'b011:  n = 3'b101;
      3'b101:  n = 3'b111;
      default: n = 3'b001;
    endcase
    return n;
  endfunction

  // Bit i of the result is p[i % 3] for i < width, zero above.
  function automatic logic [31:0] expand_op(input logic [2:0] p, input int unsigned width);
    logic [31:0] r;
    logic [2:0]  q;
    r = '0;
    q = p;
    for (int unsigned i = 0; i < 32; i++) begin
      if (i < width) begin
        r = r | (32'(q[0]) << i);
      end
      q = {q[0], q[2:1]};
    end
    return r;
  endfunction

endpackage

// File: rtl/ft_rca_pattern_gen.sv
// 3-bit test code sequencer.
//   clk  : clock
//   rst  : synchronous active-high reset (code returns to PAT_FIRST)
//   load : force the code to PAT_FIRST (wins over adv)
//   adv  : step to the next code in the sequence
//   pat  : current test code
module ft_rca_pattern_gen
  import ft_rca_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       adv,
  output logic [2:0] pat
);

  logic [2:0] pat_q;

  always_ff @(posedge clk) begin
    if (rst || load) begin
      pat_q <= PAT_FIRST;
    end else if (adv) begin
      pat_q <= next_pat(pat_q);
    end
  end

  assign pat = pat_q;

endmodule

// File: rtl/ft_rca_bist_ctrl.sv
// BIST and spare-selection controller for a bank of redundant ripple-carry adders.
//   clk, rst      : clock, synchronous active-high reset
//   start         : test request, honoured only in IDLE
//   sum_i, cout_i : result of the unit addressed by unit_sel_o
//   op_a_o, op_b_o, cin_o : test vector (zero outside a test)
//   unit_sel_o    : unit under test while busy, else active_unit_o
//   test_mode_o   : bank operand muxes select the test vector
//   busy_o        : test in progress
//   done_o        : single-cycle completion pulse
//   fault_map_o   : bit i set when unit i failed any vector
//   active_unit_o : lowest-index healthy unit
//   all_failed_o  : no healthy unit found
module ft_rca_bist_ctrl
  import ft_rca_pkg::*;
#(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned N_UNITS = 3,
  parameter int unsigned SETTLE  = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   sum_i,
  input  logic               cout_i,
  output logic [WIDTH-1:0]   op_a_o,
  output logic [WIDTH-1:0]   op_b_o,
  output logic               cin_o,
  output logic [2:0]         unit_sel_o,
  output logic               test_mode_o,
  output logic               busy_o,
  output logic               done_o,
  output logic [N_UNITS-1:0] fault_map_o,
  output logic [2:0]         active_unit_o,
  output logic               all_failed_o
);

  localparam int unsigned CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  state_e             state_q;
  logic [CW-1:0]      cnt_q;
  logic [2:0]         unit_q;
  logic [N_UNITS-1:0] fault_q;
  logic [2:0]         active_q;
  logic               all_failed_q;
  logic               busy_q;
  logic               done_q;

  logic [2:0]         pat;
  logic               pat_load;
  logic               pat_adv;
  logic [31:0]        exp_a;
  logic [31:0]        exp_b;
  logic [WIDTH-1:0]   vec_a;
  logic [WIDTH-1:0]   vec_b;
  logic               vec_cin;
  logic [WIDTH:0]     golden;
  logic               mismatch;
  logic               last_pat;
  logic               last_unit;
  logic [2:0]         pick;
  logic               found;
  logic [N_UNITS-1:0] fshift;

  ft_rca_pattern_gen u_pat (
    .clk  (clk),
    .rst  (rst),
    .load (pat_load),
    .adv  (pat_adv),
    .pat  (pat)
  );

  always_comb begin
    exp_a    = expand_op(pat, WIDTH);
    exp_b    = expand_op({pat[1:0], pat[2]}, WIDTH);
    vec_a    = exp_a[WIDTH-1:0];
    vec_b    = exp_b[WIDTH-1:0];
    vec_cin  = pat[2];
    golden   = {1'b0, vec_a} + {1'b0, vec_b} + (WIDTH+1)'(vec_cin);
    mismatch = (golden != {cout_i, sum_i});
    last_pat  = (pat == PAT_LAST);
    last_unit = (unit_q == 3'(N_UNITS - 1));
    pat_load = ((state_q == ST_IDLE) && start) ||
               ((state_q == ST_CHECK) && last_pat && !last_unit);
    pat_adv  = (state_q == ST_CHECK) && !last_pat;
  end

  // Lowest-index unit whose fault bit is clear.
  always_comb begin
    pick   = '0;
    found  = 1'b0;
    fshift = '0;
    for (int unsigned i = 0; i < N_UNITS; i++) begin
      fshift = fault_q >> i;
      if (!found && !fshift[0]) begin
        pick  = 3'(i);
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      unit_q       <= '0;
      fault_q      <= '0;
      active_q     <= '0;
      all_failed_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            fault_q <= '0;
            unit_q  <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= ST_APPLY;
          end
        end
        ST_APPLY: begin
          if (cnt_q == CW'(SETTLE - 1)) begin
            cnt_q   <= '0;
            state_q <= ST_CHECK;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_CHECK: begin
          if (mismatch) begin
            fault_q <= fault_q | (N_UNITS'(1) << unit_q);
          end
          if (!last_pat) begin
            state_q <= ST_APPLY;
          end else if (!last_unit) begin
            unit_q  <= unit_q + 3'd1;
            state_q <= ST_APPLY;
          end else begin
            state_q <= ST_SELECT;
          end
        end
        ST_SELECT: begin
          active_q     <= found ? pick : 3'd0;
          all_failed_q <= !found;
          busy_q       <= 1'b0;
          done_q       <= 1'b1;
          state_q      <= ST_DONE;
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign op_a_o        = busy_q ? vec_a : '0;
  assign op_b_o        = busy_q ? vec_b : '0;
  assign cin_o         = busy_q ? vec_cin : 1'b0;
  assign test_mode_o   = busy_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign unit_sel_o    = busy_q ? unit_q : active_q;
  assign fault_map_o   = fault_q;
  assign active_unit_o = active_q;
  assign all_failed_o  = all_failed_q;

endmodule

// File: tb/tb_ft_rca_bist_ctrl.sv
// Self-checking bench for ft_rca_bist_ctrl with a behavioural adder bank
// whose units can carry sum[0] stuck-at-0 or cout stuck-at-1 faults.
module tb_ft_rca_bist_ctrl;

  localparam int unsigned W = 4;
  localparam int unsigned N = 3;
  localparam int unsigned S = 2;
  localparam int unsigned DONE_AT = 2 + N * 8 * (S + 1);

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] sum_i;
  logic         cout_i;
  logic [W-1:0] op_a_o;
  logic [W-1:0] op_b_o;
  logic         cin_o;
  logic [2:0]   unit_sel_o;
  logic         test_mode_o;
  logic         busy_o;
  logic         done_o;
  logic [N-1:0] fault_map_o;
  logic [2:0]   active_unit_o;
  logic         all_failed_o;

  logic [N-1:0] sa0_mask;
  logic [N-1:0] sa1_mask;
  logic [W:0]   bank_r;
  logic [N-1:0] sel_sa0;
  logic [N-1:0] sel_sa1;

  int unsigned n_vec  = 0;
  int unsigned n_fail = 0;

  ft_rca_bist_ctrl #(.WIDTH(W), .N_UNITS(N), .SETTLE(S)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .sum_i         (sum_i),
    .cout_i        (cout_i),
    .op_a_o        (op_a_o),
    .op_b_o        (op_b_o),
    .cin_o         (cin_o),
    .unit_sel_o    (unit_sel_o),
    .test_mode_o   (test_mode_o),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .fault_map_o   (fault_map_o),
    .active_unit_o (active_unit_o),
    .all_failed_o  (all_failed_o)
  );

  always #5 clk = ~clk;

  // Adder bank: selected unit's sum, with that unit's planted faults.
  always_comb begin
    bank_r  = {1'b0, op_a_o} + {1'b0, op_b_o} + {{W{1'b0}}, cin_o};
    sel_sa0 = sa0_mask >> unit_sel_o;
    sel_sa1 = sa1_mask >> unit_sel_o;
    if (unit_sel_o < 3'(N) && sel_sa0[0]) bank_r[0] = 1'b0;
    if (unit_sel_o < 3'(N) && sel_sa1[0]) bank_r[W] = 1'b1;
  end
  assign sum_i  = bank_r[W-1:0];
  assign cout_i = bank_r[W];

  typedef struct {
    string        name;
    logic [N-1:0] sa0;
    logic [N-1:0] sa1;
    logic [N-1:0] exp_fault;
    logic [2:0]   exp_active;
    logic         exp_allfail;
  } vec_t;

  vec_t tbl[5];

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Pulse start for one edge, then watch 76 cycles; cycle 1 is the first after the start edge.
  task automatic run_and_check(input vec_t v);
    int unsigned ndone;
    int unsigned dcyc;
    ndone = 0;
    dcyc  = 0;
    sa0_mask = v.sa0;
    sa1_mask = v.sa1;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    for (int unsigned n = 1; n <= DONE_AT + 2; n++) begin
      if (n == 1) begin
        chk({v.name, " busy@k+1"}, busy_o, 1);
        chk({v.name, " tmode@k+1"}, test_mode_o, 1);
        chk({v.name, " op_a v0"}, op_a_o, 4'b1001);
        chk({v.name, " op_b v0"}, op_b_o, 4'b0010);
        chk({v.name, " cin v0"}, cin_o, 0);
        chk({v.name, " unit@1"}, unit_sel_o, 0);
      end
      if (n == 25) chk({v.name, " unit@25"}, unit_sel_o, 1);
      if (n == 49) chk({v.name, " unit@49"}, unit_sel_o, 2);
      if (n == 73) chk({v.name, " busy@select"}, busy_o, 1);
      if (done_o) begin
        ndone++;
        dcyc = n;
      end
      @(negedge clk);
    end
    chk({v.name, " done count"}, ndone, 1);
    chk({v.name, " done cycle"}, dcyc, DONE_AT);
    chk({v.name, " fault_map"}, fault_map_o, v.exp_fault);
    chk({v.name, " active"}, active_unit_o, v.exp_active);
    chk({v.name, " all_failed"}, all_failed_o, v.exp_allfail);
    chk({v.name, " unit_sel idle"}, unit_sel_o, v.exp_active);
    chk({v.name, " tmode idle"}, test_mode_o, 0);
    chk({v.name, " op_a idle"}, op_a_o, 0);
  endtask

  initial begin
    int unsigned ndone;
    int unsigned dcyc;
    int unsigned busy_seen;

    tbl[0] = '{"healthy",   3'b000, 3'b000, 3'b000, 3'd0, 1'b0};
    tbl[1] = '{"u0_sum0",   3'b001, 3'b000, 3'b001, 3'd1, 1'b0};
    tbl[2] = '{"u02_cout",  3'b000, 3'b101, 3'b101, 3'd1, 1'b0};
    tbl[3] = '{"all_bad",   3'b011, 3'b100, 3'b111, 3'd0, 1'b1};
    tbl[4] = '{"u01_sum0",  3'b011, 3'b000, 3'b011, 3'd2, 1'b0};

    rst = 1'b1;
    start = 1'b0;
    sa0_mask = '0;
    sa1_mask = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst busy", busy_o, 0);
    chk("rst done", done_o, 0);
    chk("rst ops", {op_a_o, op_b_o, cin_o, test_mode_o}, 0);
    chk("rst unit_sel", unit_sel_o, 0);
    chk("rst fault_map", fault_map_o, 0);
    chk("rst active", {active_unit_o, all_failed_o}, 0);

    busy_seen = 0;
    for (int unsigned n = 0; n < 10; n++) begin
      if (busy_o || done_o || test_mode_o) busy_seen++;
      @(negedge clk);
    end
    chk("idle no activity", busy_seen, 0);

    foreach (tbl[i]) run_and_check(tbl[i]);

    // start held for 5 edges, re-pulsed at k+30: only one test runs
    sa0_mask = '0;
    sa1_mask = '0;
    ndone = 0;
    dcyc = 0;
    @(negedge clk) start = 1'b1;
    @(negedge clk);
    for (int unsigned n = 1; n <= DONE_AT + 2; n++) begin
      if (n == 5) start = 1'b0;
      if (n == 30) start = 1'b1;
      if (n == 31) start = 1'b0;
      if (done_o) begin
        ndone++;
        dcyc = n;
      end
      @(negedge clk);
    end
    chk("held start done count", ndone, 1);
    chk("held start done cycle", dcyc, DONE_AT);

    // rst during CHECK of unit 1, vector 4 (cycle 25 + 3*3 + 2 = 36)
    sa0_mask = 3'b001;
    sa1_mask = '0;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    for (int unsigned n = 1; n < 36; n++) @(negedge clk);
    chk("pre-rst unit", unit_sel_o, 1);
    chk("pre-rst fault_map", fault_map_o, 3'b001);
    rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    chk("mid-rst busy", busy_o, 0);
    chk("mid-rst tmode", test_mode_o, 0);
    chk("mid-rst fault_map", fault_map_o, 0);
    chk("mid-rst done", done_o, 0);
    chk("mid-rst unit_sel", unit_sel_o, 0);
    ndone = 0;
    for (int unsigned n = 0; n < 80; n++) begin
      if (done_o) ndone++;
      @(negedge clk);
    end
    chk("mid-rst no done", ndone, 0);
    run_and_check(tbl[0]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
